// File: rtl/resource_responder_pkg.sv
// Shared types and defaults for the resource responder and its arbiter.
// State encodings include CLEAR, used only when RESOURCE_RESP_CLEAR_EN is defined.
package resource_responder_pkg;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_HANDLE_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_CLEAR  = 2'd3
  } rr_state_e;

  // Index width for a port count; a single port still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/resource_responder_arb.sv
// Round-robin arbiter: search starts one past the last grant and wraps.
// Purely combinational; emits a one-hot grant plus its index.
module rr_arbiter
  import resource_responder_pkg::*;
#(
  parameter  int N_PORTS = 2,
  localparam int IW      = idx_w(N_PORTS)
) (
  input  logic [N_PORTS-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [N_PORTS-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = 1; i <= N_PORTS; i++) begin
      if (!o_any && i_req[IW'((int'(i_last) + i) % N_PORTS)]) begin
        o_any                                         = 1'b1;
        o_grant[IW'((int'(i_last) + i) % N_PORTS)] = 1'b1;
        o_idx                                         = IW'((int'(i_last) + i) % N_PORTS);
      end
    end
  end

endmodule

// File: rtl/resource_responder.sv
// Responder for the resource request protocol: arbitrates N_PORTS branches onto one word store.
// Optional RESOURCE_RESP_CLEAR_EN zeroes the whole store after every reset.
module resource_responder
  import resource_responder_pkg::*;
#(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int HANDLE_WIDTH     = DEF_HANDLE_WIDTH,
  parameter int N_PORTS          = 2,
  parameter int N_HANDLES        = 16,
  parameter int WORDS_PER_HANDLE = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [N_PORTS-1:0]           read_req,
  input  logic [N_PORTS-1:0]           write_req,
  input  logic [N_PORTS*HANDLE_WIDTH-1:0] handle,
  input  logic [N_PORTS*DATA_WIDTH-1:0]   arg_a,
  input  logic [N_PORTS*DATA_WIDTH-1:0]   arg_b,
  output logic [N_PORTS-1:0]           read_valid,
  output logic [N_PORTS-1:0]           write_ack,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         busy
);

  localparam int HB    = $clog2(N_HANDLES);
  localparam int WB    = $clog2(WORDS_PER_HANDLE);
  localparam int AW    = HB + WB;
  localparam int DEPTH = N_HANDLES * WORDS_PER_HANDLE;
  localparam int IW    = idx_w(N_PORTS);

  rr_state_e             r_state;
  logic [IW-1:0]         r_last;
  logic [IW-1:0]         r_gidx;
  logic                  r_wr;
  logic [AW-1:0]         r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [N_PORTS-1:0]    w_req;
  logic [N_PORTS-1:0]    w_grant;
  logic [IW-1:0]         w_gidx;
  logic                  w_any;
  logic [AW-1:0]         w_addr;
  logic                  w_unused;

`ifdef RESOURCE_RESP_CLEAR_EN
  logic                  r_clr_pend;
  logic [AW-1:0]         r_clr_addr;
`endif

  assign w_req  = read_req | write_req;
  // Upper handle/offset bits are dropped so offsets wrap inside a region.
  assign w_addr = {handle[int'(w_gidx)*HANDLE_WIDTH +: HB], arg_a[int'(w_gidx)*DATA_WIDTH +: WB]};
  assign busy   = (r_state != ST_IDLE);
  assign w_unused = ^{handle, arg_a, w_grant};

  rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
    .i_req  (w_req),
    .i_last (r_last),
    .o_grant(w_grant),
    .o_idx  (w_gidx),
    .o_any  (w_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_last     <= IW'(N_PORTS - 1);
      r_gidx     <= '0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      read_valid <= '0;
      write_ack  <= '0;
      data_out   <= '0;
`ifdef RESOURCE_RESP_CLEAR_EN
      r_clr_pend <= 1'b1;
      r_clr_addr <= '0;
`endif
    end else if (enable) begin
      case (r_state)
        ST_IDLE: begin
`ifdef RESOURCE_RESP_CLEAR_EN
          if (r_clr_pend) begin
            r_clr_pend <= 1'b0;
            r_clr_addr <= '0;
            r_state    <= ST_CLEAR;
          end else
`endif
          if (w_any) begin
            r_gidx  <= w_gidx;
            r_wr    <= write_req[w_gidx];
            r_addr  <= w_addr;
            r_wdata <= arg_b[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_wr) write_ack[r_gidx] <= 1'b1;
          else begin
            read_valid[r_gidx] <= 1'b1;
            data_out           <= r_mem[r_addr];
          end
          r_last  <= r_gidx;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          read_valid <= '0;
          write_ack  <= '0;
          r_state    <= ST_IDLE;
        end
`ifdef RESOURCE_RESP_CLEAR_EN
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == AW'(DEPTH - 1)) r_state <= ST_IDLE;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Reset wins over a pending ACCESS write so an interrupted write is dropped.
  always_ff @(posedge clk) begin
    if (!reset && enable) begin
      if (r_state == ST_ACCESS && r_wr) r_mem[r_addr] <= r_wdata;
`ifdef RESOURCE_RESP_CLEAR_EN
      else if (r_state == ST_CLEAR) r_mem[r_clr_addr] <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_resource_responder.sv
// Randomized + directed bench for resource_responder against a transaction-level model.
// Model: per-port FIFOs of pending ops, round-robin pick, flat word array.
module tb_resource_responder;

  localparam int DW = 16, HW = 8, NP = 2, NH = 16, WPH = 64, DEPTH = NH * WPH;

  logic              clk = 1'b0;
  logic              reset, enable;
  logic [NP-1:0]     read_req, write_req, read_valid, write_ack;
  logic [NP*HW-1:0]  handle;
  logic [NP*DW-1:0]  arg_a, arg_b;
  logic [DW-1:0]     data_out;
  logic              busy;

  resource_responder #(
    .DATA_WIDTH(DW), .HANDLE_WIDTH(HW), .N_PORTS(NP), .N_HANDLES(NH), .WORDS_PER_HANDLE(WPH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .read_req(read_req), .write_req(write_req),
    .handle(handle), .arg_a(arg_a), .arg_b(arg_b),
    .read_valid(read_valid), .write_ack(write_ack),
    .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    bit            rd;
    bit            wr;
    logic [HW-1:0] h;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_t;

  op_t           ops[$];
  logic [DW-1:0] mdl_mem [DEPTH];
  bit            mdl_ok  [DEPTH];
  int            last_g;
  int            errors = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic int maddr(input logic [HW-1:0] h, input logic [DW-1:0] a);
    return (int'(h) % NH) * WPH + (int'(a) % WPH);
  endfunction

  function automatic int head_of(input int p);
    int r = -1;
    for (int i = 0; i < ops.size(); i++)
      if (r < 0 && ops[i].port == p) r = i;
    return r;
  endfunction

  task automatic push(input int p, input bit rd, input bit wr, input int h, input int a, input int b);
    op_t o;
    o.port = p; o.rd = rd; o.wr = wr;
    o.h = HW'(h); o.a = DW'(a); o.b = DW'(b);
    ops.push_back(o);
  endtask

  task automatic drive_heads();
    int hi;
    read_req = '0; write_req = '0;
    for (int p = 0; p < NP; p++) begin
      hi = head_of(p);
      if (hi >= 0) begin
        read_req[p]          = ops[hi].rd;
        write_req[p]         = ops[hi].wr;
        handle[p*HW +: HW]   = ops[hi].h;
        arg_a[p*DW +: DW]    = ops[hi].a;
        arg_b[p*DW +: DW]    = ops[hi].b;
      end
    end
  endtask

  // Entered and left at a falling edge with the DUT idle.
  task automatic run_ops();
    int guard = 0;
    while (ops.size() > 0 && guard < 500) begin
      int p, hi, ad;
      guard++;
      drive_heads();
      check("idle_busy", busy, 0);
      check("idle_pulse", {read_valid, write_ack}, 0);
      p = -1;
      for (int i = 1; i <= NP; i++)
        if (p < 0 && head_of((last_g + i) % NP) >= 0) p = (last_g + i) % NP;
      hi = head_of(p);
      ad = maddr(ops[hi].h, ops[hi].a);
      @(negedge clk);
      check("access_busy", busy, 1);
      check("access_pulse", {read_valid, write_ack}, 0);
      @(negedge clk);
      if (ops[hi].wr) begin
        check("write_ack", write_ack, 32'(1) << p);
        check("wr_no_rv", read_valid, 0);
        mdl_mem[ad] = ops[hi].b;
        mdl_ok[ad]  = 1'b1;
      end else begin
        check("read_valid", read_valid, 32'(1) << p);
        check("rd_no_wa", write_ack, 0);
        if (mdl_ok[ad]) check("data_out", data_out, mdl_mem[ad]);
      end
      ops.delete(hi);
      last_g = p;
      drive_heads();
      @(negedge clk);
    end
    if (ops.size() > 0) check("run_guard", ops.size(), 0);
  endtask

  // Called at the falling edge where reset was just released.
  task automatic wait_ready();
`ifdef RESOURCE_RESP_CLEAR_EN
    int n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < DEPTH + 10) begin
      n++;
      @(negedge clk);
    end
    check("clear_len", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      mdl_mem[i] = '0;
      mdl_ok[i]  = 1'b1;
    end
`endif
  endtask

  task automatic freeze_test();
    int ad = maddr(3, 5);
    read_req = 2'b01; write_req = '0;
    handle[0 +: HW] = 8'd3; arg_a[0 +: DW] = 16'd5;
    @(negedge clk);
    @(negedge clk);
    check("frz_rv0", read_valid, 2'b01);
    check("frz_data0", data_out, mdl_mem[ad]);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("frz_rv_hold", read_valid, 2'b01);
      check("frz_data_hold", data_out, mdl_mem[ad]);
      check("frz_busy", busy, 1);
    end
    enable = 1'b1; read_req = '0;
    @(negedge clk);
    check("frz_rv_done", read_valid, 0);
    check("frz_idle", busy, 0);
    last_g = 0;
  endtask

  task automatic reset_test();
    push(0, 0, 1, 5, 9, 16'h5555);
    run_ops();
    write_req = 2'b01; read_req = '0;
    handle[0 +: HW] = 8'd5; arg_a[0 +: DW] = 16'd9; arg_b[0 +: DW] = 16'hDEAD;
    @(negedge clk);
    check("rst_access_busy", busy, 1);
    reset = 1'b1; write_req = '0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_wa", write_ack, 0);
    check("rst_rv", read_valid, 0);
    check("rst_dout", data_out, 0);
    reset = 1'b0;
    last_g = NP - 1;
    wait_ready();
    push(0, 1, 0, 5, 9, 0);
    run_ops();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b1;
    read_req = '0; write_req = '0; handle = '0; arg_a = '0; arg_b = '0;
    last_g = NP - 1;
    for (int i = 0; i < DEPTH; i++) mdl_ok[i] = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_rv", read_valid, 0);
    check("reset_wa", write_ack, 0);
    check("reset_dout", data_out, 0);
    reset = 1'b0;
    wait_ready();

    // basic write then read
    push(0, 0, 1, 3, 5, 16'h1234);
    push(0, 1, 0, 3, 5, 0);
    run_ops();
    // offset wraps within region
    push(0, 0, 1, 2, 69, 16'hBEEF);
    push(0, 1, 0, 2, 5, 0);
    push(0, 1, 0, 3, 5, 0);
    run_ops();
    // two ports contending continuously
    for (int i = 0; i < 3; i++) begin
      push(0, 1, 0, 3, 5, 0);
      push(1, 1, 0, 2, 5, 0);
    end
    run_ops();
    // read+write on one port: write wins
    push(1, 1, 1, 1, 7, 16'h00AA);
    push(1, 1, 0, 1, 7, 0);
    run_ops();

    freeze_test();
    push(1, 1, 0, 2, 69, 0);
    push(0, 1, 0, 1, 7, 0);
    run_ops();

    reset_test();

    for (int i = 0; i < 40; i++) begin
      int k = int'($urandom_range(0, 3));
      push(int'($urandom_range(0, NP - 1)), k != 2, k >= 2,
           int'($urandom_range(0, 3)) + 16 * int'($urandom_range(0, 15)),
           int'($urandom_range(0, 7)) + 64 * int'($urandom_range(0, 1023)),
           int'($urandom_range(0, 65535)));
    end
    run_ops();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
